// File: rtl/btn_pkg.sv
// Shared constants and state encoding for the push-button debouncer.
package btn_pkg;

  localparam int unsigned DIV_W_DEF      = 16;
  localparam int unsigned STABLE_N_DEF   = 4;
  localparam int unsigned RPT_DELAY_DEF  = 384;
  localparam int unsigned RPT_PERIOD_DEF = 76;
  localparam int unsigned RPT_EN_DEF     = 1;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RPT_W = 10;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-clk tick every 2^DIV_W cycles.
module tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_nxt_c;

  assign cnt_nxt_c = cnt_q + DIV_W'(1);

  // tick is registered so it is high exactly while the counter holds all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt_c;
      tick  <= (cnt_nxt_c == {DIV_W{1'b1}});
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer with press/release pulses and auto-repeat step output.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned STABLE_N   = STABLE_N_DEF,
  parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
  parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF,
  parameter int unsigned RPT_EN     = RPT_EN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step
);

  localparam logic [CNT_W-1:0] STABLE_C     = CNT_W'(STABLE_N);
  localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(RPT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RELOAD_C = RPT_W'(RPT_DELAY - RPT_PERIOD);

  logic             tick;
  logic [1:0]       sync_q;
  logic             pressed_c;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc_c;
  logic             rpt_evt_c;
  logic             press_d, release_d, level_d, step_d;

  tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchroniser; reset value is the released (high) level of btn_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], btn_n};
  end

  assign pressed_c = ~sync_q[1];
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign rpt_inc_c = rpt_q + RPT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    rpt_evt_c = 1'b0;

    if (tick) begin
      // Repeat cadence runs on every tick spent pressed, including release checks
      if (state_q == ST_HELD || state_q == ST_REL_CHK) begin
        if (rpt_inc_c == RPT_DELAY_C) begin
          rpt_evt_c = 1'b1;
          rpt_d     = RPT_RELOAD_C;
        end else begin
          rpt_d = rpt_inc_c;
        end
      end

      case (state_q)
        ST_RELEASED: begin
          if (pressed_c) begin
            if (STABLE_N == 1) begin
              state_d = ST_HELD;
              press_d = 1'b1;
              rpt_d   = '0;
            end else begin
              state_d = ST_PRESS_CHK;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_PRESS_CHK: begin
          if (!pressed_c) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_inc_c == STABLE_C) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
            rpt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        ST_HELD: begin
          if (!pressed_c) begin
            if (STABLE_N == 1) begin
              state_d   = ST_RELEASED;
              release_d = 1'b1;
            end else begin
              state_d = ST_REL_CHK;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_REL_CHK: begin
          if (pressed_c) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_inc_c == STABLE_C) begin
            state_d   = ST_RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    level_d = (state_d == ST_HELD) || (state_d == ST_REL_CHK);
    step_d  = press_d | (rpt_evt_c & (RPT_EN != 0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RELEASED;
      cnt_q         <= '0;
      rpt_q         <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rpt_q         <= rpt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      step          <= step_d;
    end
  end

endmodule
